step1_scheduler: RTL and testbench



---
 rtl/pomdp_pkg.sv | 40 ++++
 rtl/step1_scheduler_if.sv | 20 ++
 rtl/step1_mac.sv | 68 ++++++
 rtl/step1_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_step1_scheduler.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pomdp_pkg.sv
// -----------------------------------------------------------------------------
// pomdp_pkg
// Shared constants and helpers for the PBVI step-1 gamma scheduler.
//   W            operand/result width (unsigned fixed point)
//   NUM_*        problem dimensions (actions l, observations k, alphas j, states i)
//   ADDR_W       gamma buffer write address width
//   *_W          index counter widths
//   step1_state_t scheduler FSM state encoding
//   gamma_addr() flat gamma buffer address of entry (l,k,j,i)
// -----------------------------------------------------------------------------
package pomdp_pkg;

   localparam int W           = 16;
   localparam int NUM_ACTIONS = 3;
   localparam int NUM_OBS     = 2;
   localparam int NUM_ALPHA   = 16;
   localparam int NUM_STATES  = 2;   // each entry is a two-term sum, so fixed at 2
   localparam int ADDR_W      = 8;

   localparam int L_W = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;
   localparam int K_W = (NUM_OBS     > 1) ? $clog2(NUM_OBS)     : 1;
   localparam int J_W = (NUM_ALPHA   > 1) ? $clog2(NUM_ALPHA)   : 1;
   localparam int I_W = (NUM_STATES  > 1) ? $clog2(NUM_STATES)  : 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MUL0  = 3'd1,
      ST_MUL1  = 3'd2,
      ST_SCALE = 3'd3,
      ST_WRITE = 3'd4,
      ST_FIN   = 3'd5
   } step1_state_t;

   // i fastest, then j, then k, then l
   function automatic logic [ADDR_W-1:0] gamma_addr(input int l, input int k,
                                                     input int j, input int i);
      return ADDR_W'(((l * NUM_OBS + k) * NUM_ALPHA + j) * NUM_STATES + i);
   endfunction

endpackage

// File: rtl/step1_scheduler_if.sv
// -----------------------------------------------------------------------------
// step1_scheduler_if
// Result write port into the gamma buffer, with sink backpressure.
//   wr_en     result valid (master -> slave)
//   wr_addr   gamma buffer address (master -> slave)
//   wr_data   result value (master -> slave)
//   wr_ready  sink accepts when high together with wr_en (slave -> master)
// -----------------------------------------------------------------------------
interface step1_scheduler_if;
   import pomdp_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [W-1:0]      wr_data;
   logic              wr_ready;

   modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/step1_mac.sv
// -----------------------------------------------------------------------------
// step1_mac
// Shared three-operand multiplier, 49-bit accumulator and discount scaling.
//   clk, rst   clock, synchronous active-high reset
//   clr        acc <= t*o*a
//   acc_en     acc <= acc + t*o*a
//   scale_en   result <= bits [63:48] of (acc*discount mod 2^64)
//   op_t/o/a   trans, observe, alpha operands for the current term
//   discount   latched discount factor
//   result     registered 16-bit scaled result
// -----------------------------------------------------------------------------
module step1_mac
   import pomdp_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         acc_en,
   input  logic         scale_en,
   input  logic [W-1:0] op_t,
   input  logic [W-1:0] op_o,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] discount,
   output logic [W-1:0] result
);
   localparam int P2    = 2 * W;
   localparam int P3    = 3 * W;
   localparam int P4    = 4 * W;
   localparam int ACC_W = 3 * W + 1;

   logic [P2-1:0]    to_prod;
   logic [P3-1:0]    term;
   logic [P4-1:0]    scale_prod;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [W-1:0]     result_q, result_d;
   logic             unused_scale_low;

   assign to_prod = P2'(op_t) * P2'(op_o);
   assign term    = P3'(to_prod) * P3'(op_a);

   // Computing in 64 bits drops the 65th product bit, which is the modulo 2^64 wrap.
   assign scale_prod       = P4'(acc_q) * P4'(discount);
   assign unused_scale_low = ^scale_prod[P4-W-1:0];

   always_comb begin
      acc_d    = acc_q;
      result_d = result_q;
      if (clr)
         acc_d = ACC_W'(term);
      else if (acc_en)
         acc_d = acc_q + ACC_W'(term);
      if (scale_en)
         result_d = scale_prod[P4-1 -: W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: rtl/step1_scheduler.sv
// -----------------------------------------------------------------------------
// step1_scheduler
// Time-multiplexed PBVI step-1 gamma sequencer: walks every (l,k,j,i) entry,
// computes it on the shared MAC in 4 cycles and streams it out the write port.
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle run request (ignored unless idle)
//   discount   discount factor, latched on accepted start
//   alpha      alpha[j][n], j major
//   trans      trans[l][i][n], l,i,n major-to-minor
//   observe    observe[i][k][n]; only i<2, k<2 read
//   wr         result write port (master)
//   busy       pass in progress
//   done       one-cycle pulse after the last write is accepted
// -----------------------------------------------------------------------------
module step1_scheduler
   import pomdp_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [W-1:0]                 discount,
   input  logic [NUM_ALPHA*2*W-1:0]     alpha,
   input  logic [NUM_ACTIONS*2*2*W-1:0] trans,
   input  logic [NUM_ACTIONS*2*2*W-1:0] observe,
   step1_scheduler_if.master            wr,
   output logic                         busy,
   output logic                         done
);
   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_MUL0  = ST_MUL0;
   localparam logic [2:0] S_MUL1  = ST_MUL1;
   localparam logic [2:0] S_SCALE = ST_SCALE;
   localparam logic [2:0] S_WRITE = ST_WRITE;
   localparam logic [2:0] S_FIN   = ST_FIN;

   logic [2:0]        state_q, state_d;
   logic [L_W-1:0]    l_q, l_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [J_W-1:0]    j_q, j_d;
   logic [I_W-1:0]    i_q, i_d;
   logic [W-1:0]      disc_q, disc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              mac_clr, mac_acc, mac_scale, n_sel, last_entry;
   logic [W-1:0]      mac_result;
   logic              unused_obs;

   // Unpack operand buses into indexable arrays.
   logic [W-1:0] alpha_arr [NUM_ALPHA][2];
   logic [W-1:0] trans_arr [NUM_ACTIONS][NUM_STATES][2];
   logic [W-1:0] obs_arr   [NUM_STATES][NUM_OBS][2];

   for (genvar gi = 0; gi < NUM_ALPHA; gi++) begin : g_alpha
      for (genvar gn = 0; gn < 2; gn++) begin : g_n
         assign alpha_arr[gi][gn] = alpha[(gi*2+gn)*W +: W];
      end
   end

   for (genvar gi = 0; gi < NUM_ACTIONS; gi++) begin : g_trans
      for (genvar gs = 0; gs < NUM_STATES; gs++) begin : g_s
         for (genvar gn = 0; gn < 2; gn++) begin : g_n
            assign trans_arr[gi][gs][gn] = trans[((gi*NUM_STATES+gs)*2+gn)*W +: W];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_obs
      for (genvar gk = 0; gk < NUM_OBS; gk++) begin : g_k
         for (genvar gn = 0; gn < 2; gn++) begin : g_n
            assign obs_arr[gi][gk][gn] = observe[((gi*NUM_OBS+gk)*2+gn)*W +: W];
         end
      end
   end

   // The observe bus is sized per action but only the i<2, k<2 slice is used.
   assign unused_obs = ^observe[NUM_ACTIONS*4*W-1:NUM_STATES*NUM_OBS*2*W];

   assign last_entry = (l_q == L_W'(NUM_ACTIONS-1)) && (k_q == K_W'(NUM_OBS-1)) &&
                       (j_q == J_W'(NUM_ALPHA-1))   && (i_q == I_W'(NUM_STATES-1));

   always_comb begin
      state_d   = state_q;
      l_d       = l_q;
      k_d       = k_q;
      j_d       = j_q;
      i_d       = i_q;
      disc_d    = disc_q;
      addr_d    = addr_q;
      mac_clr   = 1'b0;
      mac_acc   = 1'b0;
      mac_scale = 1'b0;
      n_sel     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               disc_d  = discount;
               l_d     = '0;
               k_d     = '0;
               j_d     = '0;
               i_d     = '0;
               state_d = S_MUL0;
            end
         end
         S_MUL0: begin
            mac_clr = 1'b1;
            state_d = S_MUL1;
         end
         S_MUL1: begin
            n_sel   = 1'b1;
            mac_acc = 1'b1;
            state_d = S_SCALE;
         end
         S_SCALE: begin
            mac_scale = 1'b1;
            addr_d    = gamma_addr(int'(l_q), int'(k_q), int'(j_q), int'(i_q));
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            // Indices only move on acceptance, so a stalled entry stays put.
            if (wr.wr_ready) begin
               if (last_entry) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_MUL0;
                  if (i_q != I_W'(NUM_STATES-1)) begin
                     i_d = i_q + I_W'(1);
                  end else begin
                     i_d = '0;
                     if (j_q != J_W'(NUM_ALPHA-1)) begin
                        j_d = j_q + J_W'(1);
                     end else begin
                        j_d = '0;
                        if (k_q != K_W'(NUM_OBS-1)) begin
                           k_d = k_q + K_W'(1);
                        end else begin
                           k_d = '0;
                           l_d = l_q + L_W'(1);
                        end
                     end
                  end
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         l_q     <= '0;
         k_q     <= '0;
         j_q     <= '0;
         i_q     <= '0;
         disc_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         k_q     <= k_d;
         j_q     <= j_d;
         i_q     <= i_d;
         disc_q  <= disc_d;
         addr_q  <= addr_d;
      end
   end

   step1_mac u_mac (
      .clk      (clk),
      .rst      (rst),
      .clr      (mac_clr),
      .acc_en   (mac_acc),
      .scale_en (mac_scale),
      .op_t     (trans_arr[l_q][i_q][n_sel]),
      .op_o     (obs_arr[i_q][k_q][n_sel]),
      .op_a     (alpha_arr[j_q][n_sel]),
      .discount (disc_q),
      .result   (mac_result)
   );

   assign wr.wr_en   = (state_q == S_WRITE);
   assign wr.wr_addr = addr_q;
   assign wr.wr_data = mac_result;
   assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done       = (state_q == S_FIN);

endmodule

// File: tb/tb_step1_scheduler.sv
// -----------------------------------------------------------------------------
// tb_step1_scheduler
// Self-checking bench for step1_scheduler: directed and randomized passes
// compared against an arithmetic reference model of the gamma entries.
// -----------------------------------------------------------------------------
module tb_step1_scheduler;
   import pomdp_pkg::*;

   localparam int N_ENT = NUM_ACTIONS * NUM_OBS * NUM_ALPHA * NUM_STATES;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [W-1:0] discount = '0;
   logic [NUM_ALPHA*2*W-1:0] alpha = '0;
   logic [NUM_ACTIONS*4*W-1:0] trans = '0;
   logic [NUM_ACTIONS*4*W-1:0] observe = '0;
   logic busy, done;

   step1_scheduler_if wr ();

   step1_scheduler dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .discount (discount),
      .alpha    (alpha),
      .trans    (trans),
      .observe  (observe),
      .wr       (wr),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference operands
   logic [15:0] m_alpha [NUM_ALPHA][2];
   logic [15:0] m_trans [NUM_ACTIONS][2][2];
   logic [15:0] m_obs   [2][2][2];
   logic [15:0] exp_val [256];

   // per-pass observations
   int          wr_cnt [256];
   logic [15:0] wr_val [256];
   int          order_err, first_wr, done_cyc, done_cnt, total_wr, hold_cycles, aborted;
   logic        hold_changed, busy1, busy_done, ab_wr_en, ab_busy, ab_done;
   logic [15:0] hold_data;

   task automatic set_uniform(input logic [15:0] t, input logic [15:0] o, input logic [15:0] a);
      for (int j = 0; j < NUM_ALPHA; j++) for (int n = 0; n < 2; n++) m_alpha[j][n] = a;
      for (int l = 0; l < NUM_ACTIONS; l++) for (int i = 0; i < 2; i++) for (int n = 0; n < 2; n++) m_trans[l][i][n] = t;
      for (int i = 0; i < 2; i++) for (int k = 0; k < 2; k++) for (int n = 0; n < 2; n++) m_obs[i][k][n] = o;
   endtask

   task automatic set_random();
      for (int j = 0; j < NUM_ALPHA; j++) for (int n = 0; n < 2; n++) m_alpha[j][n] = 16'($urandom);
      for (int l = 0; l < NUM_ACTIONS; l++) for (int i = 0; i < 2; i++) for (int n = 0; n < 2; n++) m_trans[l][i][n] = 16'($urandom);
      for (int i = 0; i < 2; i++) for (int k = 0; k < 2; k++) for (int n = 0; n < 2; n++) m_obs[i][k][n] = 16'($urandom);
   endtask

   // Pack model operands onto the buses; unread observe slices get noise.
   task automatic load_buses();
      for (int j = 0; j < NUM_ALPHA; j++) for (int n = 0; n < 2; n++) alpha[(j*2+n)*16 +: 16] = m_alpha[j][n];
      for (int l = 0; l < NUM_ACTIONS; l++) for (int i = 0; i < 2; i++) for (int n = 0; n < 2; n++)
         trans[((l*2+i)*2+n)*16 +: 16] = m_trans[l][i][n];
      for (int c = 8; c < NUM_ACTIONS*4; c++) observe[c*16 +: 16] = 16'($urandom);
      for (int i = 0; i < 2; i++) for (int k = 0; k < 2; k++) for (int n = 0; n < 2; n++)
         observe[((i*2+k)*2+n)*16 +: 16] = m_obs[i][k][n];
   endtask

   // Reference: entries emitted in order i fastest, then j, k, l; value is the
   // top 16 bits of (sum of two exact triple products) * discount, mod 2^64.
   task automatic compute_model(input logic [15:0] disc);
      int a = 0;
      logic [63:0] s, f;
      for (int l = 0; l < NUM_ACTIONS; l++)
         for (int k = 0; k < NUM_OBS; k++)
            for (int j = 0; j < NUM_ALPHA; j++)
               for (int i = 0; i < NUM_STATES; i++) begin
                  s = 64'(m_trans[l][i][0]) * 64'(m_obs[i][k][0]) * 64'(m_alpha[j][0])
                    + 64'(m_trans[l][i][1]) * 64'(m_obs[i][k][1]) * 64'(m_alpha[j][1]);
                  f = s * 64'(disc);
                  exp_val[a] = f[63:48];
                  a++;
               end
   endtask

   task automatic run_pass(input logic [15:0] disc, input int stall_addr, input int stall_len,
                           input int restart_cyc, input int abort_addr, input bit rand_ready);
      int cyc = 0;
      int next_addr = 0;
      int stall_left = stall_len;
      int a;
      for (int x = 0; x < 256; x++) begin wr_cnt[x] = 0; wr_val[x] = '0; end
      order_err = 0; first_wr = -1; done_cyc = -1; done_cnt = 0; total_wr = 0;
      hold_cycles = 0; hold_changed = 1'b0; aborted = 0; busy1 = 1'b0; busy_done = 1'b1;
      hold_data = '0;
      @(negedge clk);
      start = 1'b1; discount = disc; wr.wr_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      discount = 16'($urandom);
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) busy1 = busy;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; busy_done = busy; end
         end
         if (wr.wr_en && first_wr < 0) first_wr = cyc;
         if (cyc == restart_cyc) begin start = 1'b1; discount = 16'h1234; end
         else start = 1'b0;
         if (abort_addr >= 0 && wr.wr_en && int'(wr.wr_addr) == abort_addr) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            ab_wr_en = wr.wr_en; ab_busy = busy; ab_done = done; aborted = 1;
            rst = 1'b0;
            break;
         end
         if (wr.wr_en && stall_len > 0 && int'(wr.wr_addr) == stall_addr) begin
            if (hold_cycles == 0) hold_data = wr.wr_data;
            else if (wr.wr_data !== hold_data) hold_changed = 1'b1;
            hold_cycles++;
         end
         if (stall_left > 0 && wr.wr_en && int'(wr.wr_addr) == stall_addr) begin
            wr.wr_ready = 1'b0;
            stall_left--;
         end else if (rand_ready) wr.wr_ready = ($urandom_range(0, 3) != 0);
         else wr.wr_ready = 1'b1;
         if (wr.wr_en && wr.wr_ready) begin
            a = int'(wr.wr_addr);
            if (a != next_addr) order_err++;
            next_addr = a + 1;
            wr_cnt[a]++;
            wr_val[a] = wr.wr_data;
            total_wr++;
            $display("WR cycle=%0d addr=%0d data=%h", cyc, a, wr.wr_data);
         end
         if (done_cyc >= 0 && cyc > done_cyc + 3) break;
      end
      start = 1'b0;
      wr.wr_ready = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b1; discount = 16'h8000;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (wr.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b want=0", wr.wr_en); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (wr.wr_addr !== 8'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d want=0", wr.wr_addr); end
      checks++; if (wr.wr_data !== 16'd0) begin failures++; $display("FAIL reset_wr_data got=%h want=0000", wr.wr_data); end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored busy got=%b want=0", busy); end
   endtask

   task automatic test_uniform();
      set_uniform(16'h8000, 16'h8000, 16'h8000); load_buses(); compute_model(16'h8000);
      run_pass(16'h8000, -1, 0, -1, -1, 1'b0);
      for (int a = 0; a < N_ENT; a++) begin
         checks++;
         if (wr_cnt[a] !== 1 || wr_val[a] !== exp_val[a]) begin
            failures++; $display("FAIL uniform_entry addr=%0d got=%h x%0d want=%h x1", a, wr_val[a], wr_cnt[a], exp_val[a]);
         end
      end
      checks++; if (wr_val[N_ENT-1] !== 16'h2000) begin failures++; $display("FAIL uniform_last_value got=%h want=2000", wr_val[N_ENT-1]); end
      checks++; if (total_wr !== N_ENT || order_err !== 0) begin failures++; $display("FAIL uniform_order writes=%0d order_err=%0d want=%0d/0", total_wr, order_err, N_ENT); end
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL uniform_busy_c1 got=%b want=1", busy1); end
      checks++; if (first_wr !== 4) begin failures++; $display("FAIL uniform_first_wr got=%0d want=4", first_wr); end
      checks++; if (done_cyc !== 769 || done_cnt !== 1) begin failures++; $display("FAIL uniform_done cycle=%0d count=%0d want=769/1", done_cyc, done_cnt); end
      checks++; if (busy_done !== 1'b0) begin failures++; $display("FAIL uniform_busy_at_done got=%b want=0", busy_done); end
   endtask

   task automatic test_truncation();
      set_uniform(16'h8000, 16'h8000, 16'h8000); load_buses(); compute_model(16'hFFFF);
      run_pass(16'hFFFF, -1, 0, -1, -1, 1'b0);
      for (int a = 0; a < N_ENT; a++) begin
         checks++;
         if (wr_cnt[a] !== 1 || wr_val[a] !== exp_val[a]) begin
            failures++; $display("FAIL trunc_entry addr=%0d got=%h x%0d want=%h x1", a, wr_val[a], wr_cnt[a], exp_val[a]);
         end
      end
      checks++; if (wr_val[0] !== 16'h3FFF) begin failures++; $display("FAIL trunc_value got=%h want=3fff", wr_val[0]); end
   endtask

   task automatic test_wraparound();
      set_uniform(16'hFFFF, 16'hFFFF, 16'hFFFF); load_buses(); compute_model(16'hFFFF);
      run_pass(16'hFFFF, -1, 0, -1, -1, 1'b0);
      for (int a = 0; a < N_ENT; a++) begin
         checks++;
         if (wr_cnt[a] !== 1 || wr_val[a] !== exp_val[a]) begin
            failures++; $display("FAIL wrap_entry addr=%0d got=%h x%0d want=%h x1", a, wr_val[a], wr_cnt[a], exp_val[a]);
         end
      end
      checks++; if (wr_val[100] !== 16'hFFF8) begin failures++; $display("FAIL wrap_value got=%h want=fff8", wr_val[100]); end
   endtask

   task automatic test_index_map();
      set_uniform(16'h8000, 16'h8000, 16'h0000);
      m_alpha[5][0] = 16'h8000; m_alpha[5][1] = 16'h8000;
      load_buses(); compute_model(16'h8000);
      run_pass(16'h8000, -1, 0, -1, -1, 1'b0);
      for (int a = 0; a < N_ENT; a++) begin
         checks++;
         if (wr_cnt[a] !== 1 || wr_val[a] !== exp_val[a]) begin
            failures++; $display("FAIL index_entry addr=%0d got=%h x%0d want=%h x1", a, wr_val[a], wr_cnt[a], exp_val[a]);
         end
      end
      checks++; if (wr_val[64+32+11] !== 16'h2000) begin failures++; $display("FAIL index_hit addr=107 got=%h want=2000", wr_val[107]); end
      checks++; if (wr_val[12] !== 16'h0000) begin failures++; $display("FAIL index_miss addr=12 got=%h want=0000", wr_val[12]); end
   endtask

   task automatic test_backpressure();
      set_uniform(16'h8000, 16'h8000, 16'h8000); load_buses(); compute_model(16'h8000);
      run_pass(16'h8000, 7, 5, 100, -1, 1'b0);
      checks++; if (hold_cycles !== 6 || hold_changed !== 1'b0) begin failures++; $display("FAIL bp_hold cycles=%0d changed=%b want=6/0", hold_cycles, hold_changed); end
      checks++; if (total_wr !== N_ENT || order_err !== 0) begin failures++; $display("FAIL bp_order writes=%0d order_err=%0d want=%0d/0", total_wr, order_err, N_ENT); end
      checks++; if (done_cnt !== 1 || done_cyc !== 774) begin failures++; $display("FAIL bp_done count=%0d cycle=%0d want=1/774", done_cnt, done_cyc); end
      for (int a = 0; a < N_ENT; a++) begin
         checks++;
         if (wr_cnt[a] !== 1 || wr_val[a] !== exp_val[a]) begin
            failures++; $display("FAIL bp_entry addr=%0d got=%h x%0d want=%h x1", a, wr_val[a], wr_cnt[a], exp_val[a]);
         end
      end
   endtask

   task automatic test_reset_midpass();
      set_uniform(16'h8000, 16'h8000, 16'h8000); load_buses(); compute_model(16'h8000);
      run_pass(16'h8000, -1, 0, -1, 50, 1'b0);
      checks++; if (aborted !== 1) begin failures++; $display("FAIL midrst_reached got=%0d want=1", aborted); end
      checks++; if (ab_wr_en !== 1'b0 || ab_busy !== 1'b0 || ab_done !== 1'b0) begin
         failures++; $display("FAIL midrst_outputs wr_en=%b busy=%b done=%b want=0/0/0", ab_wr_en, ab_busy, ab_done);
      end
      checks++; if (total_wr !== 50 || done_cnt !== 0) begin failures++; $display("FAIL midrst_partial writes=%0d done=%0d want=50/0", total_wr, done_cnt); end
      run_pass(16'h8000, -1, 0, -1, -1, 1'b0);
      checks++; if (first_wr !== 4) begin failures++; $display("FAIL midrst_first_wr got=%0d want=4", first_wr); end
      checks++; if (done_cyc !== 769 || done_cnt !== 1) begin failures++; $display("FAIL midrst_done cycle=%0d count=%0d want=769/1", done_cyc, done_cnt); end
      checks++; if (total_wr !== N_ENT || order_err !== 0) begin failures++; $display("FAIL midrst_order writes=%0d order_err=%0d want=%0d/0", total_wr, order_err, N_ENT); end
      checks++; if (wr_val[0] !== exp_val[0]) begin failures++; $display("FAIL midrst_first_value got=%h want=%h", wr_val[0], exp_val[0]); end
   endtask

   task automatic test_random();
      logic [15:0] d;
      for (int r = 0; r < 2; r++) begin
         set_random(); load_buses();
         d = 16'($urandom);
         compute_model(d);
         run_pass(d, -1, 0, 300, -1, 1'b1);
         checks++; if (total_wr !== N_ENT || order_err !== 0 || done_cnt !== 1) begin
            failures++; $display("FAIL random_pass%0d writes=%0d order_err=%0d done=%0d want=%0d/0/1", r, total_wr, order_err, done_cnt, N_ENT);
         end
         for (int a = 0; a < N_ENT; a++) begin
            checks++;
            if (wr_cnt[a] !== 1 || wr_val[a] !== exp_val[a]) begin
               failures++; $display("FAIL random_entry pass=%0d addr=%0d got=%h x%0d want=%h x1", r, a, wr_val[a], wr_cnt[a], exp_val[a]);
            end
         end
      end
   endtask

   initial begin
      wr.wr_ready = 1'b1;
      test_reset();
      test_uniform();
      test_truncation();
      test_wraparound();
      test_index_map();
      test_backpressure();
      test_reset_midpass();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
